key_matrix_scanner: RTL and testbench
=====================================

# key_matrix_scanner

Scans a 4x4 passive key matrix and reports debounced key presses, one key at a time. It drives the columns low one at a time and reads the pulled-up row lines. A press is accepted only after it is seen as the same single key on several consecutive samples. It sits beside the LED matrix driver in the top level and shares the same internal oscillator clock.

## Interface
Parameters:
- SETTLE_CYCLES, default 1000: clocks each column is driven before the rows are sampled. Must be >= 3.
- DEBOUNCE_SCANS, default 4: consecutive matching samples needed to accept a press, and again to accept a release. Must be >= 1.

Ports:
- clk  in  1: system clock (internal oscillator).
- reset  in  1: asynchronous, active-high reset.
- row  in  4: row sense lines, active-low, externally pulled up, asynchronous to clk.
- col  out  4: column drive, active-low, exactly one bit low at all times.
- key_code  out  4: {col_index[1:0], row_index[1:0]} of the last accepted key.
- key_valid  out  1: one-cycle pulse when a new debounced press is accepted.
- key_held  out  1: high while the accepted key is still considered pressed.

## Operation
- row passes through a 2-flop synchronizer, giving row_s. All decisions use row_s.
- Timer counts 0..SETTLE_CYCLES-1 and then wraps. The sample point is the cycle where timer == SETTLE_CYCLES-1.
- Timer reloads to 0 on every column change and on every state change.
- A sample is "single" when exactly one bit of row_s is low. It is "none" when all bits are high. It is "multi" when two or more bits are low.

States:
- SCAN
  - At each sample point, single: capture cand = {col_idx, row_idx}, clear cnt to 1, go to DEBOUNCE. Column stays driven.
  - None or multi: advance col_idx (3 wraps to 0). Multi is treated as ghosting and ignored.
  - If DEBOUNCE_SCANS == 1, a single sample goes straight to accept.
- DEBOUNCE (column frozen)
  - At each sample point, single with the same row as cand: cnt++.
  - When cnt reaches DEBOUNCE_SCANS: key_code <= cand, pulse key_valid, set key_held, go to HELD.
  - Any other sample: clear cnt, advance col_idx, go to SCAN.
- HELD (column frozen)
  - Other keys are ignored, in every column and every row.
  - At each sample point, the cand row high: rel++. The cand row low: rel <= 0.
  - When rel reaches DEBOUNCE_SCANS: clear key_held, clear rel, advance col_idx, go to SCAN.
- col = ~(4'b0001 << col_idx) in every state.
- key_code holds its value until the next accept. It is not cleared on release.
- Widths:
  - timer is $clog2(SETTLE_CYCLES) bits.
  - cnt and rel are $clog2(DEBOUNCE_SCANS+1) bits and never wrap.
- Illegal or unused state encodings go to SCAN.

## Timing
Reset values (asynchronous, take effect immediately when reset rises):
- state = SCAN, col_idx = 0, col = 4'b1110, timer = 0, cnt = rel = 0.
- key_code = 0, key_valid = 0, key_held = 0, synchronizer flops = 4'b1111.

Cycle-level behaviour:
- Each column is driven for exactly SETTLE_CYCLES clocks while scanning, so a full scan takes 4*SETTLE_CYCLES clocks.
- The sample at cycle T is registered, so key_valid and key_held rise together in cycle T+1. key_valid is high for that one cycle only.
- key_held falls in the cycle after the DEBOUNCE_SCANS-th consecutive release sample.
- Press latency, from a stable row change to key_valid: at most 2 (synchronizer) + 4*SETTLE_CYCLES + (DEBOUNCE_SCANS-1)*SETTLE_CYCLES + 1 clocks.
- When a reject or a release advances the column, the new column is driven from the next cycle, with a full SETTLE_CYCLES period.

Boundary and corner cases:
- Reset while in HELD or DEBOUNCE: outputs return to their reset values at once. No key_valid is issued afterwards for the key that was being processed, unless it is re-debounced from SCAN.
- A press that spans a column change is picked up on a later scan pass.

## Test plan
Bench parameters: SETTLE_CYCLES=4, DEBOUNCE_SCANS=2.
1. Reset, no keys pressed -> col = 1110 with all outputs 0. col then rotates 1110, 1101, 1011, 0111, 1110 with each value lasting 4 clocks. key_valid never asserts.
2. row[1] is tied low whenever col[2] is low (key col 2, row 1) -> exactly one key_valid pulse with key_code = 4'b1001, key_held = 1, and col frozen at 1011 while the key is held.
3. Key col 2/row 1 is low for one sample only, then high -> no key_valid, and scanning resumes at col = 0111.
4. In column 1, row[0] and row[3] are both low -> no key_valid, cnt stays 0, and the rotation continues uninterrupted.
5. Key 4'b1001 is held and key col 0/row 2 is also pressed -> no new pulse. Release 4'b1001 -> key_held drops after 2 high samples and scanning resumes at col 3. The scan then wraps to column 0 and produces key_valid with key_code = 4'b0010.
6. reset is asserted asynchronously mid-HELD, between clock edges -> col = 1110 and key_held = 0 immediately, with no key_valid afterwards until the key is re-debounced.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// 4x4 key matrix scanner: walks one active-low column at a time, samples the
// synchronized rows once per column period and debounces one key at a time.
module key_matrix_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SCANS_NEEDED = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [3:0]    row_meta, row_sync;
  logic [TW-1:0] timer;
  logic [1:0]    col_idx, col_idx_next;
  logic [3:0]    cand, cand_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [CW-1:0] rel, rel_next, rel_inc;
  logic [3:0]    key_code_next;
  logic          key_valid_next, key_held_next;
  logic          sample_point, single;
  logic [1:0]    row_idx;

  assign sample_point = (timer == TIMER_LAST);
  assign cnt_inc      = cnt + CW'(1);
  assign rel_inc      = rel + CW'(1);
  assign col          = ~(4'b0001 << col_idx);

  // Rows are asynchronous to clk; resetting to all-high reads as "no key".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer <= '0;
    else if (sample_point) timer <= '0;
    else timer <= timer + TW'(1);
  end

  always_comb begin
    single  = 1'b1;
    row_idx = 2'd0;
    case (row_sync)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state;
    col_idx_next   = col_idx;
    cand_next      = cand;
    cnt_next       = cnt;
    rel_next       = rel;
    key_code_next  = key_code;
    key_valid_next = 1'b0;
    key_held_next  = key_held;
    case (state)
      SCAN: begin
        if (sample_point) begin
          if (single) begin
            cand_next = {col_idx, row_idx};
            if (DEBOUNCE_SCANS == 1) begin
              key_code_next  = {col_idx, row_idx};
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              cnt_next       = '0;
              rel_next       = '0;
              state_next     = HELD;
            end else begin
              cnt_next   = CW'(1);
              state_next = DEBOUNCE;
            end
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample_point) begin
          if (single && (row_idx == cand[1:0])) begin
            if (cnt_inc == SCANS_NEEDED) begin
              key_code_next  = cand;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              cnt_next       = '0;
              rel_next       = '0;
              state_next     = HELD;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cnt_next     = '0;
            col_idx_next = col_idx + 2'd1;
            state_next   = SCAN;
          end
        end
      end
      HELD: begin
        // Only the accepted key's row matters; every other key is ignored.
        if (sample_point) begin
          if (row_sync[cand[1:0]]) begin
            if (rel_inc == SCANS_NEEDED) begin
              key_held_next = 1'b0;
              rel_next      = '0;
              col_idx_next  = col_idx + 2'd1;
              state_next    = SCAN;
            end else begin
              rel_next = rel_inc;
            end
          end else begin
            rel_next = '0;
          end
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx   <= 2'd0;
      cand      <= 4'd0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      col_idx   <= col_idx_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      rel       <= rel_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
      key_held  <= key_held_next;
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a physical key-matrix model drives the rows and a
// sample-level reference model predicts col/key_code/key_valid/key_held every cycle.
module tb_key_matrix_scanner;

  localparam int SETTLE = 4;
  localparam int SCANS  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int testsRun = 0;
  int testsFailed = 0;
  int validSeen = 0;

  typedef enum {M_SCAN, M_DEB, M_HELD} mode_e;
  mode_e       mMode;
  int          mTick, mCol, mKey, mHits, mRel;
  logic [15:0] mSeen1, mSeen2;
  logic        expValid, expHeld;
  logic [3:0]  expCode;
  logic [3:0]  rot [4];

  key_matrix_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(SCANS)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column, so a row reads low when any
  // pressed key in that row sits in the column currently driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  function automatic void modelReset();
    mMode = M_SCAN; mTick = 0; mCol = 0; mKey = 0; mHits = 0; mRel = 0;
    mSeen1 = '0; mSeen2 = '0;
    expValid = 1'b0; expHeld = 1'b0; expCode = 4'd0;
  endfunction

  function automatic void modelAccept();
    expCode = 4'(mKey); expValid = 1'b1; expHeld = 1'b1;
    mMode = M_HELD; mRel = 0;
  endfunction

  // Works on the set of pressed keys, seen through the two-clock synchronizer delay.
  function automatic void modelEdge();
    logic [15:0] used;
    logic [3:0]  lowRows;
    int          nLow, lowRow;
    expValid = 1'b0;
    used = mSeen2; mSeen2 = mSeen1; mSeen1 = keys;
    if (mTick < SETTLE - 1) begin
      mTick++;
      return;
    end
    mTick = 0;
    lowRows = '0; nLow = 0; lowRow = 0;
    for (int r = 0; r < 4; r++)
      if (used[mCol*4+r]) begin lowRows[r] = 1'b1; nLow++; lowRow = r; end
    case (mMode)
      M_SCAN:
        if (nLow == 1) begin
          mKey = mCol*4 + lowRow; mHits = 1;
          if (mHits >= SCANS) modelAccept(); else mMode = M_DEB;
        end else mCol = (mCol + 1) % 4;
      M_DEB:
        if (nLow == 1 && lowRow == mKey % 4) begin
          mHits++;
          if (mHits >= SCANS) modelAccept();
        end else begin
          mHits = 0; mCol = (mCol + 1) % 4; mMode = M_SCAN;
        end
      M_HELD:
        if (!lowRows[mKey % 4]) begin
          mRel++;
          if (mRel >= SCANS) begin
            expHeld = 1'b0; mRel = 0; mCol = (mCol + 1) % 4; mMode = M_SCAN;
          end
        end else mRel = 0;
      default: mMode = M_SCAN;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed == expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    logic [3:0] expCol;
    @(posedge clk);
    if (reset) modelReset(); else modelEdge();
    @(negedge clk);
    expCol = 4'hF;
    expCol[mCol] = 1'b0;
    checkOutput("col", col, expCol);
    checkOutput("key_valid", {3'b000, key_valid}, {3'b000, expValid});
    checkOutput("key_held", {3'b000, key_held}, {3'b000, expHeld});
    checkOutput("key_code", key_code, expCode);
    if (key_valid) validSeen++;
  endtask

  task automatic applyStimulus(input logic [15:0] newKeys, input int cycles);
    keys = newKeys;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic waitValid(input string tag, input int limit);
    int n = 0;
    while (key_valid !== 1'b1 && n < limit) begin tick(); n++; end
    checkOutput(tag, {3'b000, key_valid}, 4'd1);
  endtask

  task automatic waitHeldLow(input string tag, input int limit);
    int n = 0;
    while (key_held !== 1'b0 && n < limit) begin tick(); n++; end
    checkOutput(tag, {3'b000, key_held}, 4'd0);
  endtask

  task automatic waitCol(input string tag, input logic [3:0] target, input int limit);
    int n = 0;
    while (col !== target && n < limit) begin tick(); n++; end
    checkOutput(tag, col, target);
  endtask

  initial begin
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
    modelReset();

    // Reset values and idle rotation.
    #12;
    checkOutput("reset_col", col, 4'b1110);
    checkOutput("reset_code", key_code, 4'd0);
    checkOutput("reset_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("reset_held", {3'b000, key_held}, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    validSeen = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput("rotation", col, rot[(i/4)%4]);
    end
    checkCount("idle_no_valid", validSeen, 0);

    // Single key col 2 / row 1.
    validSeen = 0;
    keys = 16'h0200;
    waitValid("press_9_valid", 100);
    checkOutput("press_9_code", key_code, 4'b1001);
    checkOutput("press_9_held", {3'b000, key_held}, 4'd1);
    applyStimulus(16'h0200, 30);
    checkOutput("press_9_frozen", col, 4'b1011);
    checkCount("press_9_one_pulse", validSeen, 1);
    keys = 16'h0000;
    waitHeldLow("release_9", 40);
    checkOutput("release_9_col", col, 4'b0111);

    // One-sample glitch on col 2 / row 1.
    waitCol("align_col2", 4'b1011, 40);
    validSeen = 0;
    applyStimulus(16'h0200, 4);
    applyStimulus(16'h0000, 4);
    checkOutput("glitch_col", col, 4'b0111);
    checkCount("glitch_no_valid", validSeen, 0);

    // Two rows low in column 1 is ghosting and must not stall the scan.
    keys = 16'h0090;
    waitCol("align_col0", 4'b1110, 40);
    validSeen = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput("multi_rotation", col, rot[(i/4)%4]);
    end
    checkCount("multi_no_valid", validSeen, 0);

    // Held key masks a second key; release reveals the second one.
    validSeen = 0;
    keys = 16'h0200;
    waitValid("hold_9_valid", 100);
    applyStimulus(16'h0204, 40);
    checkCount("second_key_ignored", validSeen, 1);
    checkOutput("second_key_frozen", col, 4'b1011);
    keys = 16'h0004;
    waitHeldLow("release_9_again", 40);
    checkOutput("resume_col3", col, 4'b0111);
    waitValid("press_2_valid", 60);
    checkOutput("press_2_code", key_code, 4'b0010);

    // Asynchronous reset in the middle of HELD.
    applyStimulus(16'h0004, 3);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_col", col, 4'b1110);
    checkOutput("async_held", {3'b000, key_held}, 4'd0);
    checkOutput("async_code", key_code, 4'd0);
    tick();
    tick();
    reset = 1'b0;
    validSeen = 0;
    applyStimulus(16'h0004, 6);
    checkCount("no_valid_after_reset", validSeen, 0);
    waitValid("redebounce_valid", 40);
    checkOutput("redebounce_code", key_code, 4'b0010);

    // Random key sets held for random durations.
    for (int seg = 0; seg < 40; seg++) begin
      logic [15:0] newKeys;
      int nk;
      newKeys = '0;
      nk = $urandom_range(0, 2);
      for (int k = 0; k < nk; k++) newKeys[$urandom_range(0, 15)] = 1'b1;
      applyStimulus(newKeys, $urandom_range(3, 60));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
